// File: rtl/jtag_scan_master.sv
// rtl/jtag_scan_master.sv - JTAG initiator: TAP reset, IR/DR scans and idle clocks from a one-command host port
module jtag_scan_master #(
    parameter int CLK_DIV  = 2,
    parameter int MAX_BITS = 32,
    parameter int LEN_W    = 6
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [MAX_BITS-1:0] cmd_tdi,
    output logic                rsp_valid,
    output logic [MAX_BITS-1:0] rsp_tdo,
    output logic                busy,
    output logic                jtag_tck,
    output logic                jtag_tms,
    output logic                jtag_tdi,
    output logic                jtag_trst_n,
    input  logic                jtag_tdo
);

    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SEQ_W   = $clog2(MAX_BITS + 8);
    localparam int CNT_W   = ((LEN_W > SEQ_W) ? LEN_W : SEQ_W) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic [CNT_W-1:0] f_nbits(input logic [LEN_W-1:0] len);
        if (CNT_W'(len) > CNT_W'(MAX_BITS)) return CNT_W'(MAX_BITS);
        return CNT_W'(len);
    endfunction

    function automatic logic [CNT_W-1:0] f_pre(input logic [1:0] op);
        return (op == 2'b01) ? CNT_W'(4) : CNT_W'(3);
    endfunction

    function automatic logic [CNT_W-1:0] f_tcks(input logic [1:0] op, input logic [LEN_W-1:0] len);
        logic [CNT_W-1:0] n;
        n = f_nbits(len);
        case (op)
            2'b00:   return CNT_W'(6);
            2'b01:   return (n == '0) ? '0 : n + CNT_W'(6);
            2'b10:   return (n == '0) ? '0 : n + CNT_W'(5);
            default: return CNT_W'(len);
        endcase
    endfunction

    // Pin values {trst_n, tms, tdi} for TCK cycle idx of a command, counted from Run-Test/Idle
    function automatic logic [2:0] f_pins(input logic [1:0] op, input logic [CNT_W-1:0] n,
                                          input logic [MAX_BITS-1:0] tdi, input logic [CNT_W-1:0] idx);
        logic [CNT_W-1:0] pre;
        logic             trst_n;
        logic             tms;
        logic             d;
        pre    = f_pre(op);
        trst_n = 1'b1;
        tms    = 1'b0;
        d      = 1'b0;
        case (op)
            2'b00: begin
                tms    = (idx < CNT_W'(5));
                trst_n = !(idx < CNT_W'(5));
            end
            2'b11: tms = 1'b0;
            default: begin
                if (idx < pre) begin
                    tms = (idx == '0) || ((op == 2'b01) && (idx == C_ONE));
                end else if (idx < pre + n) begin
                    d   = |(tdi & (MAX_BITS'(1) << (idx - pre)));
                    tms = (idx == pre + n - C_ONE);
                end else begin
                    tms = (idx == pre + n);
                end
            end
        endcase
        return {trst_n, tms, d};
    endfunction

    logic [1:0]          r_state;
    logic                r_cmd_ready;
    logic [1:0]          r_op;
    logic [CNT_W-1:0]    r_n;
    logic [CNT_W-1:0]    r_t;
    logic [CNT_W-1:0]    r_idx;
    logic [DIV_W-1:0]    r_div;
    logic [MAX_BITS-1:0] r_tdi_lat;
    logic [MAX_BITS-1:0] r_cap;
    logic [MAX_BITS-1:0] r_rsp_tdo;
    logic                r_tck;
    logic                r_tms;
    logic                r_tdi;
    logic                r_trst_n;

    logic [CNT_W-1:0]    w_t_in;
    logic [CNT_W-1:0]    w_n_in;
    logic [CNT_W-1:0]    w_pre;
    logic [CNT_W-1:0]    w_bit;
    logic [CNT_W-1:0]    w_idx_next;
    logic                w_in_shift;
    logic                w_accept;

    assign w_t_in     = f_tcks(cmd_op, cmd_len);
    assign w_n_in     = f_nbits(cmd_len);
    assign w_pre      = f_pre(r_op);
    assign w_bit      = r_idx - w_pre;
    assign w_idx_next = r_idx + C_ONE;
    assign w_in_shift = (r_op[0] ^ r_op[1]) && (r_idx >= w_pre) && (r_idx < w_pre + r_n);
    assign w_accept   = cmd_valid && r_cmd_ready && (r_state == S_IDLE);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_op        <= 2'b00;
            r_n         <= '0;
            r_t         <= '0;
            r_idx       <= '0;
            r_div       <= '0;
            r_tdi_lat   <= '0;
            r_cap       <= '0;
            r_rsp_tdo   <= '0;
            r_tck       <= 1'b0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_trst_n    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    r_trst_n    <= 1'b1;
                    r_tck       <= 1'b0;
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        r_op        <= cmd_op;
                        r_n         <= w_n_in;
                        r_t         <= w_t_in;
                        r_tdi_lat   <= cmd_tdi;
                        r_idx       <= '0;
                        r_div       <= '0;
                        r_cap       <= '0;
                        if (w_t_in == '0) begin
                            r_state   <= S_DONE;
                            r_rsp_tdo <= '0;
                        end else begin
                            r_state <= S_RUN;
                            {r_trst_n, r_tms, r_tdi} <= f_pins(cmd_op, w_n_in, cmd_tdi, '0);
                        end
                    end
                end
                S_RUN: begin
                    if (r_div == DIV_LAST) begin
                        r_div <= '0;
                        if (!r_tck) begin
                            // TDO is sampled on the edge that raises TCK
                            r_tck <= 1'b1;
                            if (w_in_shift) r_cap <= r_cap | (MAX_BITS'(jtag_tdo) << w_bit);
                        end else begin
                            r_tck <= 1'b0;
                            if (r_idx == r_t - C_ONE) begin
                                r_state   <= S_DONE;
                                r_rsp_tdo <= r_cap;
                                r_tdi     <= 1'b0;
                            end else begin
                                r_idx <= w_idx_next;
                                {r_trst_n, r_tms, r_tdi} <= f_pins(r_op, r_n, r_tdi_lat, w_idx_next);
                            end
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = (r_state == S_DONE);
    assign rsp_tdo     = r_rsp_tdo;
    assign busy        = (r_state != S_IDLE);
    assign jtag_tck    = r_tck;
    assign jtag_tms    = r_tms;
    assign jtag_tdi    = r_tdi;
    assign jtag_trst_n = r_trst_n;

endmodule
